// File: rtl/multicycle_ctrl_fsm.sv
// Control FSM for the multi-cycle RV32I core: phase register, per-phase cycle counter
// and every datapath strobe, with fixed-latency or mem_ready-handshaked memory phases.
module multicycle_ctrl_fsm #(
  parameter int unsigned IF_CYCLES     = 4,
  parameter int unsigned MEM_CYCLES    = 4,
  parameter int unsigned EX_CYCLES     = 2,
  parameter int unsigned USE_MEM_READY = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  input  logic       mem_ready,
  input  logic       halt_req,
  output logic       PCWriteNotCond,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       PCSource,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       is_ecall,
  output logic       halted,
  output logic       retire,
  output logic [2:0] state
);

  localparam int unsigned CNT_W = $clog2(16);

  localparam logic [CNT_W-1:0] IF_LAST  = CNT_W'(IF_CYCLES - 1);
  localparam logic [CNT_W-1:0] MEM_LAST = CNT_W'(MEM_CYCLES - 1);
  localparam logic [CNT_W-1:0] EX_LAST  = CNT_W'(EX_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam bit               HS_MODE  = (USE_MEM_READY != 0);

  localparam logic [6:0] OP_ARITH     = 7'b0110011;
  localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM    = 7'b1110011;

  localparam logic       SRCA_PC  = 1'b0;
  localparam logic       SRCA_A   = 1'b1;
  localparam logic [1:0] SRCB_B   = 2'b00;
  localparam logic [1:0] SRCB_4   = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;
  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_FUN  = 2'b10;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             if_done, mem_done, ex_done;

  // State and phase counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and datapath strobes
  always_comb begin
    state_d        = state_q;
    PCWriteNotCond = 1'b0;
    PCWrite        = 1'b0;
    IorD           = 1'b0;
    MemRead        = 1'b0;
    MemWrite       = 1'b0;
    MemtoReg       = 1'b0;
    IRWrite        = 1'b0;
    PCSource       = 1'b0;
    RegWrite       = 1'b0;
    ALUSrcA        = SRCA_PC;
    ALUSrcB        = SRCB_B;
    ALUOp          = ALU_ADD;
    is_ecall       = 1'b0;
    halted         = 1'b0;
    retire         = 1'b0;

    if_done  = HS_MODE ? mem_ready : (cnt_q == IF_LAST);
    mem_done = HS_MODE ? mem_ready : (cnt_q == MEM_LAST);
    ex_done  = (cnt_q == EX_LAST);

    case (state_q)
      S_IF: begin
        MemRead = 1'b1;
        if (if_done) begin
          IRWrite = 1'b1;
          state_d = S_ID;
        end
      end
      S_ID: begin
        ALUSrcA = SRCA_PC;
        ALUSrcB = SRCB_4;
        case (opcode)
          OP_ARITH, OP_ARITH_IMM, OP_LOAD, OP_STORE,
          OP_BRANCH, OP_JAL, OP_JALR: state_d = S_EX;
          OP_SYSTEM: begin
            is_ecall = 1'b1;
            if (halt_req) begin
              state_d = S_HALT;
            end else begin
              PCWrite = 1'b1;
              retire  = 1'b1;
              state_d = S_IF;
            end
          end
          // Unknown opcodes retire as a NOP with PC <= PC+4
          default: begin
            PCWrite = 1'b1;
            retire  = 1'b1;
            state_d = S_IF;
          end
        endcase
      end
      S_EX: begin
        if (opcode == OP_BRANCH) begin
          if (cnt_q == '0) begin
            ALUSrcA        = SRCA_A;
            ALUSrcB        = SRCB_B;
            ALUOp          = ALU_FUN;
            PCWriteNotCond = 1'b1;
            PCSource       = 1'b1;
            if (!branch_taken) begin
              retire  = 1'b1;
              state_d = S_IF;
            end
          end else begin
            ALUSrcA = SRCA_PC;
            ALUSrcB = SRCB_IMM;
            PCWrite = 1'b1;
            retire  = 1'b1;
            state_d = S_IF;
          end
        end else begin
          case (opcode)
            OP_ARITH: begin
              ALUSrcA = SRCA_A;
              ALUOp   = ALU_FUN;
            end
            OP_ARITH_IMM: begin
              ALUSrcA = SRCA_A;
              ALUSrcB = SRCB_IMM;
              ALUOp   = ALU_FUN;
            end
            OP_LOAD, OP_STORE: begin
              ALUSrcA = SRCA_A;
              ALUSrcB = SRCB_IMM;
            end
            default: ALUSrcB = SRCB_4;
          endcase
          if (ex_done) begin
            case (opcode)
              OP_LOAD, OP_STORE:            state_d = S_MEM;
              OP_ARITH, OP_ARITH_IMM,
              OP_JAL, OP_JALR:              state_d = S_WB;
              default:                      state_d = S_IF;
            endcase
          end
        end
      end
      S_MEM: begin
        IorD = 1'b1;
        case (opcode)
          OP_LOAD: begin
            MemRead = 1'b1;
            if (mem_done) state_d = S_WB;
          end
          OP_STORE: begin
            MemWrite = 1'b1;
            if (mem_done) begin
              ALUSrcA = SRCA_PC;
              ALUSrcB = SRCB_4;
              PCWrite = 1'b1;
              retire  = 1'b1;
              state_d = S_IF;
            end
          end
          default: state_d = S_IF;
        endcase
      end
      S_WB: begin
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
        retire   = 1'b1;
        MemtoReg = (opcode == OP_LOAD);
        state_d  = S_IF;
        case (opcode)
          OP_JAL: ALUSrcB = SRCB_IMM;
          OP_JALR: begin
            ALUSrcA = SRCA_A;
            ALUSrcB = SRCB_IMM;
          end
          default: ALUSrcB = SRCB_4;
        endcase
      end
      S_HALT: halted = 1'b1;
      default: state_d = S_IF;
    endcase

    // Counter restarts on every phase change and saturates during unbounded stalls
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end

    state = state_q;

    // Everything is quiet while reset is held
    if (!reset_n) begin
      PCWriteNotCond = 1'b0;
      PCWrite        = 1'b0;
      IorD           = 1'b0;
      MemRead        = 1'b0;
      MemWrite       = 1'b0;
      MemtoReg       = 1'b0;
      IRWrite        = 1'b0;
      PCSource       = 1'b0;
      RegWrite       = 1'b0;
      ALUSrcA        = 1'b0;
      ALUSrcB        = 2'b00;
      ALUOp          = 2'b00;
      is_ecall       = 1'b0;
      halted         = 1'b0;
      retire         = 1'b0;
      state          = 3'd0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm: a phase-level instruction model builds per-cycle
// expected strobes, the stimulus drives inputs, and per-DUT monitors compare at negedge.
module tb_multicycle_ctrl_fsm;

  localparam int unsigned IFC       = 4;
  localparam int unsigned MEMC      = 4;
  localparam int unsigned EX0       = 2;
  localparam int unsigned EX1       = 3;
  localparam int unsigned HALT_HOLD = 20;

  localparam int C_ARITH = 0, C_IMM = 1, C_LOAD = 2, C_STORE = 3, C_BR = 4,
                 C_JAL = 5, C_JALR = 6, C_SYS = 7, C_UNK = 8;

  typedef struct packed {
    logic [2:0] st;
    logic       pwnc, pcw, iord, mrd, mwr, m2r, irw, psrc, regw, asa;
    logic [1:0] asb, aop;
    logic       ecall, halted, retire;
  } ov_t;

  typedef struct packed {
    ov_t        exp;
    logic [6:0] op;
    logic       bt, mr, hr;
  } cyc_t;

  logic        clk = 1'b0;
  logic        rst0_n, rst1_n;
  logic [6:0]  opcode;
  logic        branch_taken, mem_ready, halt_req;
  logic [19:0] v0, v1;
  ov_t         o0, o1;
  ov_t         q0[$];
  ov_t         q1[$];
  cyc_t        plan_q[$];
  int          checks = 0;
  int          passes = 0;
  string       tag = "reset";
  logic [6:0]  ops[10];

  always #5 clk = ~clk;

  assign o0 = ov_t'(v0);
  assign o1 = ov_t'(v1);

  multicycle_ctrl_fsm #(.IF_CYCLES(IFC), .MEM_CYCLES(MEMC), .EX_CYCLES(EX0), .USE_MEM_READY(0)) u0 (
    .clk(clk), .reset_n(rst0_n), .opcode(opcode), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .halt_req(halt_req),
    .PCWriteNotCond(v0[16]), .PCWrite(v0[15]), .IorD(v0[14]), .MemRead(v0[13]),
    .MemWrite(v0[12]), .MemtoReg(v0[11]), .IRWrite(v0[10]), .PCSource(v0[9]),
    .RegWrite(v0[8]), .ALUSrcA(v0[7]), .ALUSrcB(v0[6:5]), .ALUOp(v0[4:3]),
    .is_ecall(v0[2]), .halted(v0[1]), .retire(v0[0]), .state(v0[19:17])
  );

  multicycle_ctrl_fsm #(.IF_CYCLES(IFC), .MEM_CYCLES(MEMC), .EX_CYCLES(EX1), .USE_MEM_READY(1)) u1 (
    .clk(clk), .reset_n(rst1_n), .opcode(opcode), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .halt_req(halt_req),
    .PCWriteNotCond(v1[16]), .PCWrite(v1[15]), .IorD(v1[14]), .MemRead(v1[13]),
    .MemWrite(v1[12]), .MemtoReg(v1[11]), .IRWrite(v1[10]), .PCSource(v1[9]),
    .RegWrite(v1[8]), .ALUSrcA(v1[7]), .ALUSrcB(v1[6:5]), .ALUOp(v1[4:3]),
    .is_ecall(v1[2]), .halted(v1[1]), .retire(v1[0]), .state(v1[19:17])
  );

  function automatic void check(input string who, input ov_t act, input ov_t exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s [%s] strobes got=%05h (state %0d) want=%05h (state %0d)",
                  who, tag, act, act.st, exp, exp.st);
  endfunction

  // Monitors: one expected vector consumed per cycle whenever one is pending
  always @(negedge clk) begin
    if (q0.size() > 0) begin
      ov_t e;
      e = q0.pop_front();
      check("u0", o0, e);
    end
  end

  always @(negedge clk) begin
    if (q1.size() > 0) begin
      ov_t e;
      e = q1.pop_front();
      check("u1", o1, e);
    end
  end

  function automatic int classify(input logic [6:0] op);
    case (op)
      7'b0110011: return C_ARITH;
      7'b0010011: return C_IMM;
      7'b0000011: return C_LOAD;
      7'b0100011: return C_STORE;
      7'b1100011: return C_BR;
      7'b1101111: return C_JAL;
      7'b1100111: return C_JALR;
      7'b1110011: return C_SYS;
      default:    return C_UNK;
    endcase
  endfunction

  // Negative input values mean "don't care": drive a random bit
  task automatic add(input ov_t e, input logic [6:0] op, input int bt, input int mr, input int hr);
    cyc_t c;
    c.exp = e;
    c.op  = op;
    c.bt  = (bt < 0) ? 1'($urandom) : 1'(bt);
    c.mr  = (mr < 0) ? 1'($urandom) : 1'(mr);
    c.hr  = (hr < 0) ? 1'($urandom) : 1'(hr);
    plan_q.push_back(c);
  endtask

  // Reference model: phase sequence and per-phase strobes of one instruction
  task automatic build_plan(input logic [6:0] op, input bit taken, input bit halt, input bit hs,
                            input int ex_n, input int if_w, input int mem_w);
    ov_t v;
    int  cls, n;
    plan_q.delete();
    cls = classify(op);
    n = hs ? if_w + 1 : int'(IFC);
    for (int i = 0; i < n; i++) begin
      v = '0;
      v.mrd = 1'b1;
      v.irw = (i == n - 1);
      add(v, 7'($urandom), -1, hs ? int'(i == n - 1) : -1, -1);
    end
    v = '0;
    v.st = 3'd1;
    v.asb = 2'b01;
    if (cls == C_SYS || cls == C_UNK) begin
      v.ecall = (cls == C_SYS);
      if (cls == C_SYS && halt) begin
        add(v, op, -1, -1, 1);
        v = '0;
        v.st = 3'd5;
        v.halted = 1'b1;
        for (int i = 0; i < int'(HALT_HOLD); i++) add(v, 7'($urandom), -1, -1, -1);
      end else begin
        v.pcw = 1'b1;
        v.retire = 1'b1;
        add(v, op, -1, -1, (cls == C_SYS) ? 0 : -1);
      end
      return;
    end
    add(v, op, -1, -1, -1);
    if (cls == C_BR) begin
      v = '0;
      v.st = 3'd2; v.asa = 1'b1; v.aop = 2'b10; v.pwnc = 1'b1; v.psrc = 1'b1;
      v.retire = !taken;
      add(v, op, int'(taken), -1, -1);
      if (taken) begin
        v = '0;
        v.st = 3'd2; v.asb = 2'b10; v.pcw = 1'b1; v.retire = 1'b1;
        add(v, op, -1, -1, -1);
      end
      return;
    end
    v = '0;
    v.st = 3'd2;
    case (cls)
      C_ARITH:         begin v.asa = 1'b1; v.aop = 2'b10; end
      C_IMM:           begin v.asa = 1'b1; v.asb = 2'b10; v.aop = 2'b10; end
      C_LOAD, C_STORE: begin v.asa = 1'b1; v.asb = 2'b10; end
      default:         v.asb = 2'b01;
    endcase
    for (int i = 0; i < ex_n; i++) add(v, op, -1, -1, -1);
    if (cls == C_LOAD || cls == C_STORE) begin
      n = hs ? mem_w + 1 : int'(MEMC);
      for (int i = 0; i < n; i++) begin
        v = '0;
        v.st = 3'd3;
        v.iord = 1'b1;
        if (cls == C_LOAD) v.mrd = 1'b1;
        else begin
          v.mwr = 1'b1;
          if (i == n - 1) begin v.asb = 2'b01; v.pcw = 1'b1; v.retire = 1'b1; end
        end
        add(v, op, -1, hs ? int'(i == n - 1) : -1, -1);
      end
      if (cls == C_STORE) return;
    end
    v = '0;
    v.st = 3'd4; v.regw = 1'b1; v.pcw = 1'b1; v.retire = 1'b1;
    v.m2r = (cls == C_LOAD);
    case (cls)
      C_JAL:   v.asb = 2'b10;
      C_JALR:  begin v.asa = 1'b1; v.asb = 2'b10; end
      default: v.asb = 2'b01;
    endcase
    add(v, op, -1, -1, -1);
  endtask

  // Push expectations for the first 'upto' cycles of the plan, then drive them
  task automatic run_plan(input int which, input int upto);
    int n;
    n = (plan_q.size() < upto) ? plan_q.size() : upto;
    for (int k = 0; k < n; k++) begin
      if (which == 0) q0.push_back(plan_q[k].exp);
      else            q1.push_back(plan_q[k].exp);
    end
    for (int k = 0; k < n; k++) begin
      opcode       = plan_q[k].op;
      branch_taken = plan_q[k].bt;
      mem_ready    = plan_q[k].mr;
      halt_req     = plan_q[k].hr;
      @(posedge clk); #1;
    end
  endtask

  task automatic instr(input int which, input string name, input logic [6:0] op, input bit taken,
                       input bit halt, input int if_w, input int mem_w, input int upto);
    tag = name;
    build_plan(op, taken, halt, which == 1, (which == 1) ? int'(EX1) : int'(EX0), if_w, mem_w);
    run_plan(which, upto);
  endtask

  task automatic do_reset(input int which, input int n);
    tag = "reset";
    if (which == 0) rst0_n = 1'b0;
    else            rst1_n = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (which == 0) q0.push_back('0);
      else            q1.push_back('0);
      opcode       = 7'($urandom);
      branch_taken = 1'($urandom);
      mem_ready    = 1'($urandom);
      halt_req     = 1'($urandom);
      @(posedge clk); #1;
    end
    if (which == 0) rst0_n = 1'b1;
    else            rst1_n = 1'b1;
  endtask

  task automatic random_instrs(input int which, input int count);
    int idx;
    for (int i = 0; i < count; i++) begin
      idx = int'($urandom_range(0, 9));
      instr(which, "random", ops[idx], 1'($urandom), 1'b0,
            int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), 1000);
    end
  endtask

  initial begin
    ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011; ops[3] = 7'b0100011;
    ops[4] = 7'b1100011; ops[5] = 7'b1101111; ops[6] = 7'b1100111; ops[7] = 7'b1110011;
    ops[8] = 7'h7F;      ops[9] = 7'b0110111;
    rst0_n = 1'b1; rst1_n = 1'b1;
    opcode = '0; branch_taken = 1'b0; mem_ready = 1'b0; halt_req = 1'b0;
    #2;
    rst0_n = 1'b0; rst1_n = 1'b0;
    @(posedge clk); #1;

    // Fixed-latency controller
    do_reset(0, 3);
    instr(0, "add",        7'b0110011, 1'b0, 1'b0, 0, 0, 1000);
    instr(0, "load",       7'b0000011, 1'b0, 1'b0, 0, 0, 1000);
    instr(0, "beq_nt",     7'b1100011, 1'b0, 1'b0, 0, 0, 1000);
    instr(0, "beq_t",      7'b1100011, 1'b1, 1'b0, 0, 0, 1000);
    instr(0, "addi",       7'b0010011, 1'b0, 1'b0, 0, 0, 1000);
    instr(0, "store",      7'b0100011, 1'b0, 1'b0, 0, 0, 1000);
    instr(0, "jal",        7'b1101111, 1'b0, 1'b0, 0, 0, 1000);
    instr(0, "jalr",       7'b1100111, 1'b0, 1'b0, 0, 0, 1000);
    instr(0, "unknown",    7'h7F,      1'b0, 1'b0, 0, 0, 1000);
    instr(0, "ecall_cont", 7'b1110011, 1'b0, 1'b0, 0, 0, 1000);
    random_instrs(0, 30);
    // Abort a store in MEM cnt2 (cycle index 9 of the instruction)
    instr(0, "store_abort", 7'b0100011, 1'b0, 1'b0, 0, 0, 9);
    do_reset(0, 3);
    instr(0, "nop_7f",     7'h7F,      1'b0, 1'b0, 0, 0, 1000);
    instr(0, "ecall_halt", 7'b1110011, 1'b0, 1'b1, 0, 0, 1000);
    do_reset(0, 2);
    instr(0, "post_halt",  7'b0110011, 1'b0, 1'b0, 0, 0, 1000);
    rst0_n = 1'b0;

    // Handshake controller
    do_reset(1, 3);
    instr(1, "hs_add",     7'b0110011, 1'b0, 1'b0, 3, 0, 1000);
    instr(1, "hs_load",    7'b0000011, 1'b0, 1'b0, 0, 2, 1000);
    instr(1, "hs_store",   7'b0100011, 1'b0, 1'b0, 1, 0, 1000);
    instr(1, "hs_longif",  7'b0000011, 1'b0, 1'b0, 20, 18, 1000);
    instr(1, "hs_beq_t",   7'b1100011, 1'b1, 1'b0, 2, 0, 1000);
    random_instrs(1, 30);
    instr(1, "hs_halt",    7'b1110011, 1'b0, 1'b1, 1, 0, 1000);
    do_reset(1, 2);

    @(posedge clk); #1;
    checks++;
    if (q0.size() == 0 && q1.size() == 0) passes++;
    else $display("FAIL drain: pending expectations u0=%0d u1=%0d, want 0/0", q0.size(), q1.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
